// File: rtl/fifo_read_packer.sv
// Drains a fixed-latency FIFO read port in PAR_READ-word groups and packs PACK
// groups into one wide beat presented on a valid/ready stream.
module fifo_read_packer #(
   parameter int SIZE     = 16,
   parameter int PAR_READ = 1,
   parameter int PACK     = 4
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            clear,
   input  logic                            empty,
   output logic                            ren,
   input  logic [PAR_READ*SIZE-1:0]        din,
   input  logic                            din_valid,
   output logic [PACK*PAR_READ*SIZE-1:0]   dout,
   output logic                            dout_valid,
   input  logic                            dout_ready,
   output logic [$clog2(PACK+1)-1:0]       fill,
   output logic                            protocol_err
);

   localparam int FW = $clog2(PACK+1);
   localparam int GW = PAR_READ*SIZE;

   typedef enum logic {ST_FILL, ST_FULL} state_t;

   state_t          state_reg;
   logic [FW-1:0]   fill_reg;
   logic [FW-1:0]   fill_next;
   logic [FW-1:0]   space;
   logic            inflight_reg;
   logic            discard_reg;
   logic            protocol_err_reg;
   logic            handshake;
   logic            accept;
   logic            unsolicited;
   logic [GW-1:0]   slot_reg [PACK];

   // A beat leaving this cycle frees every slot, so the next group may land in slot 0.
   assign handshake   = (state_reg == ST_FULL) && dout_ready;
   assign space       = handshake ? '0 : fill_reg;
   assign ren         = rstn && !empty && !clear
                        && ((int'(space) + int'(inflight_reg)) < PACK);
   assign accept      = din_valid && inflight_reg && !clear;
   assign unsolicited = din_valid && !inflight_reg && !discard_reg && !clear;
   assign fill_next   = accept ? space + FW'(1) : space;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg        <= ST_FILL;
         fill_reg         <= '0;
         inflight_reg     <= 1'b0;
         discard_reg      <= 1'b0;
         protocol_err_reg <= 1'b0;
      end else if (clear) begin
         state_reg    <= ST_FILL;
         fill_reg     <= '0;
         inflight_reg <= 1'b0;
         discard_reg  <= inflight_reg;
      end else begin
         fill_reg     <= fill_next;
         state_reg    <= (fill_next == FW'(PACK)) ? ST_FULL : ST_FILL;
         inflight_reg <= ren;
         discard_reg  <= 1'b0;
         if (unsolicited)
            protocol_err_reg <= 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < PACK; gi++) begin : g_slot
         always_ff @(posedge clk) begin
            if (!rstn)
               slot_reg[gi] <= '0;
            else if (accept && (space == FW'(gi)))
               slot_reg[gi] <= din;
         end
         assign dout[gi*GW +: GW] = slot_reg[gi];
      end
   endgenerate

   assign dout_valid   = (state_reg == ST_FULL);
   assign fill         = fill_reg;
   assign protocol_err = protocol_err_reg;

endmodule

// File: tb/tb_fifo_read_packer.sv
// Directed bench for fifo_read_packer: the bench plays the FIFO and compares the
// DUT every cycle against a slot-array model of the packing rules.
module tb_fifo_read_packer;

   localparam int PACK = 4;

   logic        clk = 1'b0;
   logic        rstn, clear, empty, ren, din_valid, dout_valid, dout_ready, protocol_err;
   logic [15:0] din;
   logic [63:0] dout;
   logic [2:0]  fill;

   always #5 clk = ~clk;

   fifo_read_packer #(.SIZE(16), .PAR_READ(1), .PACK(PACK)) dut (
      .clk(clk), .rstn(rstn), .clear(clear), .empty(empty), .ren(ren),
      .din(din), .din_valid(din_valid), .dout(dout), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .fill(fill), .protocol_err(protocol_err)
   );

   int checks = 0;
   int failures = 0;

   // model state
   int          m_fill = 0;
   logic [15:0] m_words [PACK];
   bit          m_dv = 0, m_infl = 0, m_disc = 0, m_perr = 0;
   bit          armed = 0;

   // FIFO emulation
   logic [15:0] q[$];
   bit          hold, pend, inject;
   logic [15:0] pend_word, inject_word;
   int          ren_cnt;
   logic [63:0] beats[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] m_dout();
      logic [63:0] r;
      for (int i = 0; i < PACK; i++) r[i*16 +: 16] = m_words[i];
      return r;
   endfunction

   function automatic bit exp_ren();
      int sp;
      sp = (m_dv && dout_ready) ? 0 : m_fill;
      return rstn && !empty && !clear && ((sp + int'(m_infl)) < PACK);
   endfunction

   task automatic tick();
      bit          r;
      int          sp;
      bit          npend;
      logic [15:0] nword;
      empty     = hold || (q.size() == 0);
      din_valid = pend || inject;
      din       = pend ? pend_word : inject_word;
      @(negedge clk);
      r = exp_ren();
      if (armed) begin
         chk("ren", ren, r);
         chk("fill", fill, m_fill);
         chk("dout_valid", dout_valid, m_dv);
         chk("protocol_err", protocol_err, m_perr);
         if (m_dv) chk("dout", dout, m_dout());
      end
      if (dout_valid && dout_ready && rstn && !clear) beats.push_back(dout);
      npend = 0;
      nword = 16'h0;
      if (r) begin
         ren_cnt++;
         npend = 1;
         nword = q.pop_front();
      end
      if (!rstn) begin
         m_fill = 0; m_dv = 0; m_infl = 0; m_disc = 0; m_perr = 0;
         for (int i = 0; i < PACK; i++) m_words[i] = 16'h0;
      end else if (clear) begin
         m_fill = 0; m_dv = 0; m_disc = m_infl; m_infl = 0;
      end else begin
         sp = (m_dv && dout_ready) ? 0 : m_fill;
         if (din_valid && m_infl) begin
            m_words[sp] = din;
            sp++;
         end else if (din_valid && !m_disc) begin
            m_perr = 1;
         end
         m_fill = sp;
         m_dv   = (m_fill == PACK);
         m_infl = r;
         m_disc = 0;
      end
      @(posedge clk);
      #1;
      pend      = npend;
      pend_word = nword;
   endtask

   task automatic wait_beat(input string name);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!dout_valid && n < 20);
      chk(name, dout_valid, 1'b1);
   endtask

   initial begin
      int n;
      for (int i = 0; i < PACK; i++) m_words[i] = 16'h0;
      rstn = 0; clear = 0; dout_ready = 0; hold = 1; inject = 0; inject_word = 16'h0;
      pend = 0; pend_word = 16'h0; din = 16'h0; din_valid = 0; empty = 1; ren_cnt = 0;
      tick();
      armed = 1;
      tick();
      rstn = 1;
      chk("reset_fill", fill, 0);
      chk("reset_dout", dout, 0);
      chk("reset_valid", dout_valid, 0);
      chk("reset_perr", protocol_err, 0);
      chk("reset_ren", ren, 0);

      // first beat and its latency from the first ren
      q = '{16'd5, 16'd1, 16'd8, 16'd12};
      hold = 0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!dout_valid && n < 20);
      chk("first_beat_latency", n, 5);
      chk("beat0", dout, 64'h000C_0008_0001_0005);

      // backpressure with more data waiting
      q.push_back(16'd120); q.push_back(16'd130); q.push_back(16'd150); q.push_back(16'd170);
      repeat (6) begin
         tick();
         chk("bp_dout", dout, 64'h000C_0008_0001_0005);
         chk("bp_valid", dout_valid, 1'b1);
         chk("bp_ren", ren, 1'b0);
      end
      dout_ready = 1;
      tick();
      dout_ready = 0;
      chk("hs_fill", fill, 0);
      chk("hs_valid", dout_valid, 1'b0);
      wait_beat("beat1_wait");
      chk("beat1", dout, 64'h00AA_0096_0082_0078);
      dout_ready = 1;
      tick();
      dout_ready = 0;
      hold = 1;
      tick();

      // streaming with dout_ready held high
      for (int i = 1; i <= 8; i++) q.push_back(16'h1000 + 16'(i));
      beats.delete();
      ren_cnt = 0;
      dout_ready = 1;
      hold = 0;
      repeat (14) tick();
      dout_ready = 0;
      chk("stream_beats", beats.size(), 2);
      if (beats.size() == 2) begin
         chk("stream_beat0", beats[0], 64'h1004_1003_1002_1001);
         chk("stream_beat1", beats[1], 64'h1008_1007_1006_1005);
      end
      chk("stream_rens", ren_cnt, 8);

      // empty mid-beat
      q = '{16'h0015, 16'h0016, 16'h0017, 16'h0018};
      hold = 0;
      tick(); tick();
      hold = 1;
      repeat (4) tick();
      chk("stall_fill", fill, 2);
      chk("stall_ren", ren, 1'b0);
      hold = 0;
      wait_beat("resume_wait");
      chk("resume_beat", dout, 64'h0018_0017_0016_0015);
      dout_ready = 1;
      tick();
      dout_ready = 0;
      hold = 1;
      tick();

      // clear with a read in flight
      q.push_back(16'h0031);
      hold = 0;
      tick(); tick();
      chk("pre_clear_fill", fill, 1);
      q.push_back(16'h0032);
      tick();
      clear = 1;
      tick();
      clear = 0;
      hold = 1;
      chk("clear_fill", fill, 0);
      chk("clear_valid", dout_valid, 1'b0);
      chk("clear_perr", protocol_err, 1'b0);
      tick();
      chk("discard_perr", protocol_err, 1'b0);
      chk("discard_fill", fill, 0);

      // unsolicited din_valid, then reset mid-beat
      q.push_back(16'h0041);
      hold = 0;
      tick();
      hold = 1;
      tick(); tick();
      chk("partial_fill", fill, 1);
      inject = 1;
      inject_word = 16'hDEAD;
      tick();
      inject = 0;
      chk("perr_set", protocol_err, 1'b1);
      chk("perr_fill", fill, 1);
      tick(); tick();
      chk("perr_sticky", protocol_err, 1'b1);
      rstn = 0;
      tick();
      rstn = 1;
      chk("rst2_fill", fill, 0);
      chk("rst2_valid", dout_valid, 1'b0);
      chk("rst2_perr", protocol_err, 1'b0);
      chk("rst2_ren", ren, 1'b0);
      chk("rst2_dout", dout, 0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
